// File: rtl/ps2_keymap.sv
// ps2_keymap
//   Converts PS/2 scan-code set 2 bytes from ps2phy into ASCII characters
//   for the core. It follows make/break, E0 extended and E1 pause prefixes,
//   keeps shift/ctrl (and optional caps lock) state, and queues decoded
//   characters in a small FIFO so the core can stall without losing keys.
//
// Parameters
//   OUT_DEPTH  output FIFO depth in characters (power of 2, >= 2)
//
// Ports
//   clk48      in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sym_data   in   scan-code byte from ps2phy
//   sym_valid  in   sym_data valid
//   sym_ready  out  byte accepted when sym_valid && sym_ready (FIFO not full)
//   kb_data    out  decoded character at the FIFO head
//   kb_valid   out  FIFO not empty
//   kb_ready   in   core accepts; pop when kb_valid && kb_ready
//
// Configuration
//   PS2_KEYMAP_CAPSLOCK_EN  when defined, make of 58 toggles caps lock,
//                           which inverts the case of letters.
module ps2_keymap #(
   parameter int OUT_DEPTH = 4
) (
   input  logic       clk48,
   input  logic       rst_n,
   input  logic [7:0] sym_data,
   input  logic       sym_valid,
   output logic       sym_ready,
   output logic [7:0] kb_data,
   output logic       kb_valid,
   input  logic       kb_ready
);

   localparam int PW = $clog2(OUT_DEPTH);
   localparam logic [PW:0]   FULL_COUNT = (PW+1)'(OUT_DEPTH);
   localparam logic [PW:0]   CNT_ONE    = 1;
   localparam logic [PW-1:0] PTR_ONE    = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXTBRK,
      ST_PAUSE
   } state_e;

   state_e        state_q, state_d;
   logic [2:0]    pauseCnt_q, pauseCnt_d;
   logic          lshift_q, lshift_d;
   logic          rshift_q, rshift_d;
   logic          ctrl_q, ctrl_d;
   logic          capsOn;

   logic [7:0]    fifo_q [OUT_DEPTH];
   logic [PW-1:0] wrPtr_q, rdPtr_q;
   logic [PW:0]   count_q;

   logic          accept, push, pop;
   logic [7:0]    pushData;
   logic          isLetter, glyphValid, makeValid, extValid;
   logic [4:0]    letterIdx;
   logic [7:0]    glyphLo, glyphHi, makeData, extData;

`ifdef PS2_KEYMAP_CAPSLOCK_EN
   logic caps_q, caps_d;

   // Caps lock toggle register, cleared by reset.
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) caps_q <= 1'b0;
      else        caps_q <= caps_d;
   end

   assign capsOn = caps_q;
`else
   assign capsOn = 1'b0;
`endif

   assign sym_ready = (count_q != FULL_COUNT);
   assign kb_valid  = (count_q != '0);
   assign kb_data   = kb_valid ? fifo_q[rdPtr_q] : 8'h00;
   assign accept    = sym_valid && sym_ready;
   assign pop       = kb_valid && kb_ready;

   // Letter position in the alphabet (US set-2 layout).
   always_comb begin
      isLetter  = 1'b1;
      letterIdx = 5'd0;
      case (sym_data)
         8'h1C: letterIdx = 5'd0;   8'h32: letterIdx = 5'd1;   8'h21: letterIdx = 5'd2;
         8'h23: letterIdx = 5'd3;   8'h24: letterIdx = 5'd4;   8'h2B: letterIdx = 5'd5;
         8'h34: letterIdx = 5'd6;   8'h33: letterIdx = 5'd7;   8'h43: letterIdx = 5'd8;
         8'h3B: letterIdx = 5'd9;   8'h42: letterIdx = 5'd10;  8'h4B: letterIdx = 5'd11;
         8'h3A: letterIdx = 5'd12;  8'h31: letterIdx = 5'd13;  8'h44: letterIdx = 5'd14;
         8'h4D: letterIdx = 5'd15;  8'h15: letterIdx = 5'd16;  8'h2D: letterIdx = 5'd17;
         8'h1B: letterIdx = 5'd18;  8'h2C: letterIdx = 5'd19;  8'h3C: letterIdx = 5'd20;
         8'h2A: letterIdx = 5'd21;  8'h1D: letterIdx = 5'd22;  8'h22: letterIdx = 5'd23;
         8'h35: letterIdx = 5'd24;  8'h1A: letterIdx = 5'd25;
         default: isLetter = 1'b0;
      endcase
   end

   // Non-letter keys: unshifted/shifted glyph pairs; control keys map to the same code either way.
   always_comb begin
      glyphValid = 1'b1;
      glyphLo    = 8'h00;
      glyphHi    = 8'h00;
      case (sym_data)
         8'h16: begin glyphLo = 8'h31; glyphHi = 8'h21; end
         8'h1E: begin glyphLo = 8'h32; glyphHi = 8'h40; end
         8'h26: begin glyphLo = 8'h33; glyphHi = 8'h23; end
         8'h25: begin glyphLo = 8'h34; glyphHi = 8'h24; end
         8'h2E: begin glyphLo = 8'h35; glyphHi = 8'h25; end
         8'h36: begin glyphLo = 8'h36; glyphHi = 8'h5E; end
         8'h3D: begin glyphLo = 8'h37; glyphHi = 8'h26; end
         8'h3E: begin glyphLo = 8'h38; glyphHi = 8'h2A; end
         8'h46: begin glyphLo = 8'h39; glyphHi = 8'h28; end
         8'h45: begin glyphLo = 8'h30; glyphHi = 8'h29; end
         8'h0E: begin glyphLo = 8'h60; glyphHi = 8'h7E; end
         8'h4E: begin glyphLo = 8'h2D; glyphHi = 8'h5F; end
         8'h55: begin glyphLo = 8'h3D; glyphHi = 8'h2B; end
         8'h54: begin glyphLo = 8'h5B; glyphHi = 8'h7B; end
         8'h5B: begin glyphLo = 8'h5D; glyphHi = 8'h7D; end
         8'h5D: begin glyphLo = 8'h5C; glyphHi = 8'h7C; end
         8'h4C: begin glyphLo = 8'h3B; glyphHi = 8'h3A; end
         8'h52: begin glyphLo = 8'h27; glyphHi = 8'h22; end
         8'h41: begin glyphLo = 8'h2C; glyphHi = 8'h3C; end
         8'h49: begin glyphLo = 8'h2E; glyphHi = 8'h3E; end
         8'h4A: begin glyphLo = 8'h2F; glyphHi = 8'h3F; end
         8'h29: begin glyphLo = 8'h20; glyphHi = 8'h20; end
         8'h5A: begin glyphLo = 8'h0D; glyphHi = 8'h0D; end
         8'h66: begin glyphLo = 8'h08; glyphHi = 8'h08; end
         8'h0D: begin glyphLo = 8'h09; glyphHi = 8'h09; end
         8'h76: begin glyphLo = 8'h1B; glyphHi = 8'h1B; end
         default: glyphValid = 1'b0;
      endcase
   end

   // Character for a plain make code; ctrl overrides shift and caps for letters.
   always_comb begin
      makeValid = isLetter | glyphValid;
      makeData  = 8'h00;
      if (isLetter) begin
         if (ctrl_q)                              makeData = {3'b000, letterIdx + 5'd1};
         else if ((lshift_q | rshift_q) ^ capsOn) makeData = 8'h41 + {3'b000, letterIdx};
         else                                     makeData = 8'h61 + {3'b000, letterIdx};
      end else if (glyphValid) begin
         makeData = (lshift_q | rshift_q) ? glyphHi : glyphLo;
      end
   end

   // Extended (E0) make codes: cursor keys and keypad enter. Fake shifts are absent and push nothing.
   always_comb begin
      extValid = 1'b1;
      extData  = 8'h00;
      case (sym_data)
         8'h75:   extData = 8'h80;
         8'h72:   extData = 8'h81;
         8'h6B:   extData = 8'h82;
         8'h74:   extData = 8'h83;
         8'h5A:   extData = 8'h0D;
         default: extValid = 1'b0;
      endcase
   end

   // Decoder next state: advances only on accepted bytes, at most one push per byte.
   always_comb begin
      state_d    = state_q;
      pauseCnt_d = pauseCnt_q;
      lshift_d   = lshift_q;
      rshift_d   = rshift_q;
      ctrl_d     = ctrl_q;
`ifdef PS2_KEYMAP_CAPSLOCK_EN
      caps_d     = caps_q;
`endif
      push       = 1'b0;
      pushData   = 8'h00;
      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               case (sym_data)
                  8'hE0: state_d = ST_EXT;
                  8'hF0: state_d = ST_BRK;
                  8'hE1: begin
                     state_d    = ST_PAUSE;
                     pauseCnt_d = 3'd7;
                  end
                  8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: ;
                  8'h12: lshift_d = 1'b1;
                  8'h59: rshift_d = 1'b1;
                  8'h14: ctrl_d   = 1'b1;
`ifdef PS2_KEYMAP_CAPSLOCK_EN
                  8'h58: caps_d   = ~caps_q;
`endif
                  default: begin
                     push     = makeValid;
                     pushData = makeData;
                  end
               endcase
            end
            ST_EXT: begin
               state_d = ST_IDLE;
               if (sym_data == 8'hF0) begin
                  state_d = ST_EXTBRK;
               end else if (sym_data == 8'h14) begin
                  ctrl_d = 1'b1;
               end else begin
                  push     = extValid;
                  pushData = extData;
               end
            end
            ST_BRK: begin
               state_d = ST_IDLE;
               case (sym_data)
                  8'h12:   lshift_d = 1'b0;
                  8'h59:   rshift_d = 1'b0;
                  8'h14:   ctrl_d   = 1'b0;
                  default: ;
               endcase
            end
            ST_EXTBRK: begin
               state_d = ST_IDLE;
               if (sym_data == 8'h14) ctrl_d = 1'b0;
            end
            ST_PAUSE: begin
               // The pause sequence is seven bytes after E1, all swallowed.
               if (pauseCnt_q == 3'd1) begin
                  state_d    = ST_IDLE;
                  pauseCnt_d = 3'd0;
               end else begin
                  pauseCnt_d = pauseCnt_q - 3'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Decoder state and modifier registers, cleared by the asynchronous reset.
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pauseCnt_q <= 3'd0;
         lshift_q   <= 1'b0;
         rshift_q   <= 1'b0;
         ctrl_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pauseCnt_q <= pauseCnt_d;
         lshift_q   <= lshift_d;
         rshift_q   <= rshift_d;
         ctrl_q     <= ctrl_d;
      end
   end

   // Output FIFO; push only happens while not full because bytes are held off by sym_ready.
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < OUT_DEPTH; i++) fifo_q[i] <= 8'h00;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            fifo_q[wrPtr_q] <= pushData;
            wrPtr_q         <= wrPtr_q + PTR_ONE;
         end
         if (pop) rdPtr_q <= rdPtr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_keymap.sv
// tb_ps2_keymap
//   Self-checking bench for ps2_keymap. A keyboard model inside the bench
//   predicts the character stream and FIFO occupancy from the scan-code
//   rules; a compare process checks the DUT against it every cycle, and
//   each directed test also checks its popped characters against literals.
module tb_ps2_keymap;

   localparam int DEPTH = 4;

   logic       clk48 = 1'b0;
   logic       rst_n;
   logic [7:0] sym_data;
   logic       sym_valid;
   logic       sym_ready;
   logic [7:0] kb_data;
   logic       kb_valid;
   logic       kb_ready;

   int assertCount = 0;
   int failCount   = 0;

   logic [7:0] expQ[$];
   logic [7:0] popped[$];
   logic [7:0] stimQ[$];
   logic [7:0] litQ[$];

   logic mExt, mBrk, mLshift, mRshift, mCtrl, mCaps;
   int   mPause;

   logic [7:0] letterCodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] glyphCodes [21]  = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                    8'h45, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
                                    8'h41, 8'h49, 8'h4A};
   logic [7:0] glyphLoTab [21]  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                                    8'h30, 8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27,
                                    8'h2C, 8'h2E, 8'h2F};
   logic [7:0] glyphHiTab [21]  = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28,
                                    8'h29, 8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22,
                                    8'h3C, 8'h3E, 8'h3F};

   ps2_keymap #(.OUT_DEPTH(DEPTH)) dut (
      .clk48     (clk48),
      .rst_n     (rst_n),
      .sym_data  (sym_data),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .kb_data   (kb_data),
      .kb_valid  (kb_valid),
      .kb_ready  (kb_ready)
   );

   // Free-running 100 MHz-style bench clock.
   always #5 clk48 = ~clk48;

   task automatic checkEq(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic void modelReset();
      mExt = 0; mBrk = 0; mLshift = 0; mRshift = 0; mCtrl = 0; mCaps = 0; mPause = 0;
   endfunction

   // Character a plain make code types, or -1 when the key types nothing.
   function automatic int lookupMake(logic [7:0] b);
      int   ch = -1;
      logic shifted = mLshift | mRshift;
      for (int i = 0; i < 26; i++)
         if (letterCodes[i] == b) ch = mCtrl ? i + 1 : ((shifted ^ mCaps) ? 65 + i : 97 + i);
      for (int i = 0; i < 21; i++)
         if (glyphCodes[i] == b) ch = shifted ? int'(glyphHiTab[i]) : int'(glyphLoTab[i]);
      case (b)
         8'h29: ch = 32;
         8'h5A: ch = 13;
         8'h66: ch = 8;
         8'h0D: ch = 9;
         8'h76: ch = 27;
         default: ;
      endcase
      return ch;
   endfunction

   function automatic int lookupExt(logic [7:0] b);
      case (b)
         8'h75:   return 128;
         8'h72:   return 129;
         8'h6B:   return 130;
         8'h74:   return 131;
         8'h5A:   return 13;
         default: return -1;
      endcase
   endfunction

   // Feeds one accepted byte to the keyboard model; returns the typed character or -1.
   function automatic int modelByte(logic [7:0] b);
      int ch = -1;
      if (mPause > 0) begin
         mPause--;
      end else if (mBrk) begin
         if (b == 8'h14) mCtrl = 0;
         if (!mExt && b == 8'h12) mLshift = 0;
         if (!mExt && b == 8'h59) mRshift = 0;
         mBrk = 0;
         mExt = 0;
      end else if (mExt) begin
         if (b == 8'hF0) mBrk = 1;
         else begin
            mExt = 0;
            if (b == 8'h14) mCtrl = 1;
            else ch = lookupExt(b);
         end
      end else begin
         case (b)
            8'hE0: mExt = 1;
            8'hF0: mBrk = 1;
            8'hE1: mPause = 7;
            8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: ;
            8'h12: mLshift = 1;
            8'h59: mRshift = 1;
            8'h14: mCtrl = 1;
`ifdef PS2_KEYMAP_CAPSLOCK_EN
            8'h58: mCaps = ~mCaps;
`endif
            default: ch = lookupMake(b);
         endcase
      end
      return ch;
   endfunction

   // Every-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk48) begin
      int ch;
      if (!rst_n) begin
         modelReset();
         expQ.delete();
         checkEq("reset kb_valid", kb_valid, 0);
         checkEq("reset kb_data", kb_data, 0);
         checkEq("reset sym_ready", sym_ready, 1);
      end else begin
         checkEq("kb_valid vs model", kb_valid, expQ.size() != 0);
         checkEq("sym_ready vs model", sym_ready, expQ.size() != DEPTH);
         if (kb_valid && expQ.size() != 0) checkEq("kb_data vs model", kb_data, expQ[0]);
         if (kb_valid && kb_ready) begin
            popped.push_back(kb_data);
            if (expQ.size() != 0) void'(expQ.pop_front());
         end
         if (sym_valid && sym_ready) begin
            ch = modelByte(sym_data);
            if (ch >= 0) expQ.push_back(8'(ch));
         end
      end
   end

   // Presents one byte and holds it until accepted; called and returns at posedge+1.
   task automatic sendByte(input logic [7:0] b);
      int waitCycles = 0;
      sym_data  = b;
      sym_valid = 1'b1;
      @(negedge clk48);
      while (!sym_ready && waitCycles < 200) begin
         @(negedge clk48);
         waitCycles++;
      end
      if (!sym_ready) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL byte accept timeout: sym_ready 0, required 1 for byte 0x%0h", b);
      end
      @(posedge clk48);
      #1;
      sym_valid = 1'b0;
   endtask

   task automatic applyStimulus(input string name);
      $display("[TB] applying %s", name);
      foreach (stimQ[i]) sendByte(stimQ[i]);
   endtask

   task automatic waitDrain();
      int n = 0;
      while ((kb_valid || expQ.size() != 0) && n < 200) begin
         @(negedge clk48);
         n++;
      end
      if (n >= 200) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL drain timeout: kb_valid %0d, required 0", kb_valid);
      end
      repeat (3) @(negedge clk48);
      @(posedge clk48);
      #1;
   endtask

   task automatic checkOutput(input string name);
      checkEq({name, " count"}, popped.size(), litQ.size());
      for (int i = 0; i < litQ.size(); i++)
         if (i < popped.size()) checkEq($sformatf("%s char%0d", name, i), popped[i], litQ[i]);
      popped.delete();
   endtask

   task automatic runCase(input string name);
      applyStimulus(name);
      waitDrain();
      checkOutput(name);
   endtask

   // Watchdog so a hung handshake cannot stall the run forever.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed test sequence from the specification.
   initial begin
      rst_n     = 1'b0;
      sym_valid = 1'b0;
      sym_data  = 8'h00;
      kb_ready  = 1'b1;
      modelReset();
      repeat (2) @(posedge clk48);
      #3;
      rst_n = 1'b1;
      @(posedge clk48);
      #1;

      sendByte(8'h1C);
      checkEq("latency kb_valid", kb_valid, 1);
      checkEq("latency kb_data", kb_data, 8'h61);
      sendByte(8'hF0);
      sendByte(8'h1C);
      waitDrain();
      litQ = '{8'h61};
      checkOutput("make a");

      stimQ = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
      litQ  = '{8'h41, 8'h61};
      runCase("shift a");

      stimQ = '{8'h14, 8'h21, 8'hF0, 8'h21, 8'hF0, 8'h14};
      litQ  = '{8'h03};
      runCase("ctrl c");

      stimQ = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12, 8'hE0, 8'h6B};
      litQ  = '{8'h80, 8'h82};
      runCase("extended");

      stimQ = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
      litQ  = '{8'h61};
      runCase("pause");

      stimQ = '{8'h12, 8'h16, 8'h4E, 8'h52, 8'hF0, 8'h12, 8'h16, 8'h5D, 8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
      litQ  = '{8'h21, 8'h5F, 8'h22, 8'h31, 8'h5C, 8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};
      runCase("glyphs");

      stimQ = '{8'h12, 8'h14, 8'h1C, 8'hF0, 8'h14, 8'hF0, 8'h12, 8'hE0, 8'h14, 8'h1A, 8'hE0, 8'hF0, 8'h14, 8'h1A};
      litQ  = '{8'h01, 8'h1A, 8'h7A};
      runCase("ctrl variants");

      stimQ = '{8'hE0, 8'h5A, 8'hE0, 8'h74, 8'h07, 8'hE0, 8'h70, 8'hE0, 8'h72, 8'hAA, 8'hFA, 8'h00, 8'hFE, 8'hFF, 8'h1C};
      litQ  = '{8'h0D, 8'h83, 8'h81, 8'h61};
      runCase("ext and ignored");

      stimQ = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
      litQ  = '{8'h61, 8'h61, 8'h61};
      runCase("typematic");

      kb_ready = 1'b0;
      stimQ = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
      fork
         applyStimulus("backpressure");
      join_none
      repeat (8) @(posedge clk48);
      #1;
      checkEq("bp sym_ready when full", sym_ready, 0);
      checkEq("bp head held", kb_data, 8'h61);
      kb_ready = 1'b1;
      wait fork;
      waitDrain();
      litQ = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
      checkOutput("backpressure");

      kb_ready = 1'b0;
      stimQ = '{8'h12, 8'h1C};
      applyStimulus("pre-reset");
      @(posedge clk48);
      #3;
      checkEq("pre-reset kb_valid", kb_valid, 1);
      rst_n = 1'b0;
      #1;
      checkEq("async reset kb_valid", kb_valid, 0);
      @(posedge clk48);
      #3;
      rst_n = 1'b1;
      @(posedge clk48);
      #1;
      popped.delete();
      kb_ready = 1'b1;
      stimQ = '{8'h1C};
      litQ  = '{8'h61};
      runCase("after reset");

`ifdef PS2_KEYMAP_CAPSLOCK_EN
      stimQ = '{8'h58, 8'hF0, 8'h58, 8'h1C, 8'h12, 8'h1C, 8'hF0, 8'h12, 8'h58, 8'hF0, 8'h58, 8'h1C};
      litQ  = '{8'h41, 8'h61, 8'h61};
      runCase("caps lock");
`else
      stimQ = '{8'h58, 8'h1C};
      litQ  = '{8'h61};
      runCase("no caps lock");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
